fp2dec_seq: RTL

- Sequencer placed in front of the shared iterative float-to-decimal datapath, which performs the multiply-by-10 normalization and digit extraction.
- Accepts one IEEE754 single-precision word through a valid/ready handshake, classifies it, and resolves zero/inf/NaN directly without using the datapath.
- For normal numbers it computes the path select and exponent magnitude, loads the datapath and pulses its reset.
- It then waits a data-dependent, fixed-formula cycle count, captures the datapath results and presents them through an output valid/ready handshake.

---
 rtl/fp2dec_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fp2dec_seq.sv
// fp2dec_seq: classifies an IEEE754 single and resolves specials directly. For normal operands it
// sequences the iterative float-to-decimal datapath. Optional macro FP2DEC_PERF_EN adds conv_count.

module fp2dec_seq #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned GUARD  = 3,
  parameter int unsigned KW     = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [27:0]   alu_frac,
  output logic [KW-1:0] alu_exp,
  output logic          alu_path,
  output logic          alu_rst_n,
  input  logic [4:0]    alu_int,
  input  logic [8:0]    alu_exp10,
  input  logic [19:0]   alu_frac10,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [1:0]    out_class,
  output logic [4:0]    out_int,
  output logic [8:0]    out_exp10,
  output logic [19:0]   out_frac
`ifdef FP2DEC_PERF_EN
  ,
  output logic [15:0]   conv_count
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // Cycles spent in RUN beyond the exponent magnitude itself.
  localparam logic [KW-1:0] WaitExtra = KW'(2 + DIGITS + GUARD);

  state_e        state_q, state_d;
  logic          sign_q, sign_d;
  logic [1:0]    class_q, class_d;
  logic [27:0]   alu_frac_q, alu_frac_d;
  logic [KW-1:0] alu_exp_q, alu_exp_d;
  logic          alu_path_q, alu_path_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [4:0]    int_q, int_d;
  logic [8:0]    exp10_q, exp10_d;
  logic [19:0]   frac_q, frac_d;

  logic          op_sign;
  logic [7:0]    op_exp;
  logic [22:0]   op_man;
  logic [1:0]    op_class;
  logic          op_neg;
  logic [7:0]    op_k;

  // Operand unpack and classification; denormals fold into the zero class.
  always_comb begin
    op_sign = in_data[31];
    op_exp  = in_data[30:23];
    op_man  = in_data[22:0];
    if (op_exp == 8'd0) begin
      op_class = 2'b01;
    end else if (op_exp == 8'hFF) begin
      op_class = (op_man == 23'd0) ? 2'b10 : 2'b11;
    end else begin
      op_class = 2'b00;
    end
    op_neg = (op_exp < 8'd127);
    op_k   = op_neg ? (8'd127 - op_exp) : (op_exp - 8'd127);
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    class_d    = class_q;
    alu_frac_d = alu_frac_q;
    alu_exp_d  = alu_exp_q;
    alu_path_d = alu_path_q;
    cnt_d      = cnt_q;
    int_d      = int_q;
    exp10_d    = exp10_q;
    frac_d     = frac_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = op_sign;
          class_d = op_class;
          if (op_class == 2'b00) begin
            alu_frac_d = {4'b0000, 1'b1, op_man};
            alu_exp_d  = KW'(op_k);
            alu_path_d = op_neg;
            state_d    = StLoad;
          end else begin
            int_d   = 5'd0;
            exp10_d = 9'd0;
            frac_d  = 20'd0;
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        cnt_d   = alu_exp_q + WaitExtra;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          int_d   = alu_int;
          exp10_d = alu_exp10;
          frac_d  = alu_frac10;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      class_q    <= 2'b00;
      alu_frac_q <= 28'd0;
      alu_exp_q  <= '0;
      alu_path_q <= 1'b0;
      cnt_q      <= '0;
      int_q      <= 5'd0;
      exp10_q    <= 9'd0;
      frac_q     <= 20'd0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      class_q    <= class_d;
      alu_frac_q <= alu_frac_d;
      alu_exp_q  <= alu_exp_d;
      alu_path_q <= alu_path_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      exp10_q    <= exp10_d;
      frac_q     <= frac_d;
    end
  end

  // Handshake outputs are gated by RST so nothing is offered or accepted during reset.
  assign in_ready  = (state_q == StIdle) && !RST;
  assign out_valid = (state_q == StDone) && !RST;
  assign alu_rst_n = !(RST || (state_q == StLoad));

  assign alu_frac  = alu_frac_q;
  assign alu_exp   = alu_exp_q;
  assign alu_path  = alu_path_q;

  assign out_sign  = sign_q;
  assign out_class = class_q;
  assign out_int   = int_q;
  assign out_exp10 = exp10_q;
  assign out_frac  = frac_q;

`ifdef FP2DEC_PERF_EN
  logic [15:0] conv_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      conv_count_q <= 16'd0;
    end else if (out_valid && out_ready && (conv_count_q != 16'hFFFF)) begin
      conv_count_q <= conv_count_q + 16'd1;
    end
  end

  assign conv_count = conv_count_q;
`endif

endmodule
